// File: rtl/q_sys_master_0_b2p_adapter.sv
// Escaped byte stream to Avalon-ST packet decoder (SOP/EOP/CHANNEL/ESCAPE specials).
// Define Q_SYS_MASTER_0_B2P_CHANNEL_EN to keep decoded channel values; otherwise out_channel is 0.
module q_sys_master_0_b2p_adapter #(
    parameter int CHANNEL_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    output logic [CHANNEL_W-1:0] out_channel
);

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;

    typedef enum logic [1:0] {IDLE, ESC, CHAN, CHAN_ESC} state_t;

    state_t     state;
    logic       sop_pend;
    logic       eop_pend;
    logic       accept;
    logic       emit;
    logic [7:0] esc_byte;
    logic [7:0] emit_data;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign esc_byte = in_data ^ 8'h20;

    always_comb begin
        emit      = 1'b0;
        emit_data = in_data;
        if (accept) begin
            case (state)
                IDLE: emit = (in_data != SOP_CHAR) && (in_data != EOP_CHAR) &&
                             (in_data != CHAN_CHAR) && (in_data != ESC_CHAR);
                ESC: begin
                    emit      = 1'b1;
                    emit_data = esc_byte;
                end
                default: emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            sop_pend          <= 1'b0;
            eop_pend          <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else begin
            // A consumed beat drops unless a new one replaces it below.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (emit) begin
                out_valid         <= 1'b1;
                out_data          <= emit_data;
                out_startofpacket <= sop_pend;
                out_endofpacket   <= eop_pend;
                sop_pend          <= 1'b0;
                eop_pend          <= 1'b0;
            end
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (in_data == SOP_CHAR)  sop_pend <= 1'b1;
                        if (in_data == EOP_CHAR)  eop_pend <= 1'b1;
                        if (in_data == CHAN_CHAR) state    <= CHAN;
                        if (in_data == ESC_CHAR)  state    <= ESC;
                    end
                    ESC:      state <= IDLE;
                    CHAN:     state <= (in_data == ESC_CHAR) ? CHAN_ESC : IDLE;
                    CHAN_ESC: state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

`ifdef Q_SYS_MASTER_0_B2P_CHANNEL_EN
    logic [CHANNEL_W-1:0] chan_reg;
    logic [CHANNEL_W-1:0] chan_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_reg <= '0;
            chan_q   <= '0;
        end else begin
            if (emit)
                chan_q <= chan_reg;
            if (accept && state == CHAN && in_data != ESC_CHAR)
                chan_reg <= in_data[CHANNEL_W-1:0];
            if (accept && state == CHAN_ESC)
                chan_reg <= esc_byte[CHANNEL_W-1:0];
        end
    end

    assign out_channel = chan_q;
`else
    assign out_channel = '0;
`endif

endmodule

// File: tb/tb_q_sys_master_0_b2p_adapter.sv
// Directed bench for the byte-to-packet decoder; a second CHANNEL_W=2 instance shares the stream.
module tb_q_sys_master_0_b2p_adapter;

    logic       clk;
    logic       reset_n;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_startofpacket;
    logic       out_endofpacket;
    logic [7:0] out_channel;

    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_data2;
    logic       out_sop2;
    logic       out_eop2;
    logic [1:0] out_channel2;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [7:0]  exp_ch;

    q_sys_master_0_b2p_adapter #(.CHANNEL_W(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_channel       (out_channel)
    );

    q_sys_master_0_b2p_adapter #(.CHANNEL_W(2)) dut2 (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready2),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .out_ready         (out_ready),
        .out_valid         (out_valid2),
        .out_data          (out_data2),
        .out_startofpacket (out_sop2),
        .out_endofpacket   (out_eop2),
        .out_channel       (out_channel2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] chx(input logic [7:0] c);
`ifdef Q_SYS_MASTER_0_B2P_CHANNEL_EN
        return c;
`else
        return 8'h00;
`endif
    endfunction

    // Drives one byte, waits (bounded) for in_ready, returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b);
        int unsigned n;
        n = 0;
        #1;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] d, input logic s,
                               input logic e, input logic [7:0] ch);
        check(tag, {13'b0, out_valid, out_startofpacket, out_endofpacket, out_data, out_channel},
              {13'b0, 1'b1, s, e, d, ch});
    endtask

    task automatic expect_none(input string tag);
        check(tag, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_ch    = 8'h00;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        #12;
        check("rst_out", {13'b0, out_valid, out_startofpacket, out_endofpacket, out_data, out_channel}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic framing
        send(8'h7A); expect_none("sop_char");
        send(8'h11); expect_beat("b11", 8'h11, 1'b1, 1'b0, 8'h00);
        send(8'h22); expect_beat("b22", 8'h22, 1'b0, 1'b0, 8'h00);
        send(8'h7B); expect_none("eop_char");
        send(8'h33); expect_beat("b33", 8'h33, 1'b0, 1'b1, 8'h00);

        // Single-beat packet with escaped payload, repeated SOP idempotent
        send(8'h7A); send(8'h7A); send(8'h7B);
        send(8'h7D); expect_none("esc_char");
        send(8'h5A); expect_beat("b7a_single", 8'h7A, 1'b1, 1'b1, 8'h00);

        // Channel sequences, including escaped channel value
        send(8'h7C); send(8'h05); send(8'h7A); expect_none("chan_seq");
        send(8'h44); expect_beat("b44_ch", 8'h44, 1'b1, 1'b0, chx(8'h05));
        send(8'h7C); send(8'h7D); send(8'h5C); send(8'h7B);
        send(8'h55); expect_beat("b55_ch", 8'h55, 1'b0, 1'b1, chx(8'h7C));
        exp_ch = chx(8'h7C);

        // Backpressure: beat 01 stalls for 3 cycles with 02 waiting
        send(8'h7A);
        send(8'h01); expect_beat("b01", 8'h01, 1'b1, 1'b0, exp_ch);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h02;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            expect_beat("b01_hold", 8'h01, 1'b1, 1'b0, exp_ch);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        send(8'h02); expect_beat("b02", 8'h02, 1'b0, 1'b0, exp_ch);
        send(8'h03); expect_beat("b03", 8'h03, 1'b0, 1'b0, exp_ch);
        send(8'h7B); expect_none("eop_after_stall");
        send(8'h04); expect_beat("b04", 8'h04, 1'b0, 1'b1, exp_ch);

        // Reset mid-escape clears ESC state and channel
        send(8'h7D);
        reset_n = 1'b0;
        #2;
        check("rst_mid_out", {13'b0, out_valid, out_startofpacket, out_endofpacket, out_data, out_channel}, 32'd0);
        check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h7A); expect_none("sop_after_rst");
        send(8'h10); expect_beat("b10_no_esc", 8'h10, 1'b1, 1'b0, 8'h00);

        // Channel truncation on the narrow instance
        send(8'h7C); send(8'hFF);
        send(8'h20); expect_beat("b20_ch", 8'h20, 1'b0, 1'b0, chx(8'hFF));
        check("w2_beat", {22'b0, out_valid2, out_data2, out_sop2, out_eop2}, {22'b0, 1'b1, 8'h20, 1'b0, 1'b0});
        check("w2_channel", {30'b0, out_channel2}, {24'b0, chx(8'h03)});

        // Idle consumption drops out_valid
        @(posedge clk);
        #1;
        expect_none("drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
